// File: rtl/udp_hdr_strip_pkg.sv
// udp_hdr_strip_pkg
// Shared definitions for the UDP header stripper and its MoldUDP64 neighbour:
//   - UDP header byte offsets and size
//   - receive state enum
//   - byte-enable helpers (popcount of an 8-bit keep, low-n keep mask)
package udp_hdr_strip_pkg;

  localparam int UDP_HDR_DST_OFF = 2;
  localparam int UDP_HDR_LEN_OFF = 4;
  localparam int UDP_HDR_BYTES   = 8;

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    FWD  = 2'd1,
    TRIM = 2'd2,
    DROP = 2'd3
  } state_e;

  // Number of enabled bytes in a 64-bit beat.
  function automatic logic [3:0] popcount8(input logic [7:0] keep);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, keep[i]};
    return c;
  endfunction

  // Contiguous keep with the low n bytes enabled (n in 0..8).
  function automatic logic [7:0] keep_from_count(input logic [3:0] n);
    logic [7:0] m;
    for (int i = 0; i < 8; i++) m[i] = (4'(i) < n);
    return m;
  endfunction

endpackage

// File: rtl/udp_hdr_strip.sv
// udp_hdr_strip
// Validates the one-beat UDP header of each packet arriving from the IP
// layer, drops packets whose header fails, strips the header and trims
// link-layer padding using the UDP length field. Short packets are closed
// early with tuser set.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   ip_axis_*                  input AXI-Stream (packet starts at UDP header)
//   udp_axis_*                 output AXI-Stream (UDP payload only)
//   hdr_drop_o                 one-cycle pulse per packet dropped at header
//   len_err_o                  one-cycle pulse per short packet
//   drop_cnt_o                 saturating count of dropped packets
module udp_hdr_strip
  import udp_hdr_strip_pkg::*;
#(
  parameter int          AXI_DATA_W     = 64,
  parameter int          AXI_KEEP_W     = AXI_DATA_W / 8,
  parameter logic [15:0] UDP_DST_PORT   = 16'd26400,
  parameter bit          PORT_FILTER_EN = 1'b1,
  parameter logic [15:0] MIN_UDP_LEN    = 16'd28,
  parameter int          CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ip_axis_tvalid_i,
  input  logic [AXI_KEEP_W-1:0] ip_axis_tkeep_i,
  input  logic [AXI_DATA_W-1:0] ip_axis_tdata_i,
  input  logic                  ip_axis_tlast_i,
  input  logic                  ip_axis_tuser_i,
  output logic                  ip_axis_tready_o,
  output logic                  udp_axis_tvalid_o,
  output logic [AXI_KEEP_W-1:0] udp_axis_tkeep_o,
  output logic [AXI_DATA_W-1:0] udp_axis_tdata_o,
  output logic                  udp_axis_tlast_o,
  output logic                  udp_axis_tuser_o,
  input  logic                  udp_axis_tready_i,
  output logic                  hdr_drop_o,
  output logic                  len_err_o,
  output logic [CNT_W-1:0]      drop_cnt_o
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_e      state;
  logic [15:0] rem;
  logic [15:0] dst;
  logic [15:0] len;
  logic [3:0]  nbytes;
  logic        accept;
  logic        hdr_ok;
  logic        fwd_done;

  // Header fields are big-endian on the wire.
  assign dst = {ip_axis_tdata_i[UDP_HDR_DST_OFF*8 +: 8],
                ip_axis_tdata_i[(UDP_HDR_DST_OFF+1)*8 +: 8]};
  assign len = {ip_axis_tdata_i[UDP_HDR_LEN_OFF*8 +: 8],
                ip_axis_tdata_i[(UDP_HDR_LEN_OFF+1)*8 +: 8]};

  assign hdr_ok = (&ip_axis_tkeep_i) & ~ip_axis_tlast_i & ~ip_axis_tuser_i &
                  (len >= MIN_UDP_LEN) &
                  ((dst == UDP_DST_PORT) | ~PORT_FILTER_EN);

  // Single output register: a full register can be refilled in the same
  // cycle it is drained.
  assign ip_axis_tready_o = ~udp_axis_tvalid_o | udp_axis_tready_i;
  assign accept           = ip_axis_tvalid_i & ip_axis_tready_o;

  assign nbytes   = popcount8(ip_axis_tkeep_i);
  // rem never exceeds 8 when this is true, so rem[3:0] is a valid mask count.
  assign fwd_done = ({12'd0, nbytes} >= rem);

  // Stage p0: header check, payload trim and output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= HDR;
      rem               <= '0;
      udp_axis_tvalid_o <= 1'b0;
      udp_axis_tkeep_o  <= '0;
      udp_axis_tdata_o  <= '0;
      udp_axis_tlast_o  <= 1'b0;
      udp_axis_tuser_o  <= 1'b0;
      hdr_drop_o        <= 1'b0;
      len_err_o         <= 1'b0;
      drop_cnt_o        <= '0;
    end else begin
      hdr_drop_o <= 1'b0;
      len_err_o  <= 1'b0;
      if (udp_axis_tvalid_o && udp_axis_tready_i) udp_axis_tvalid_o <= 1'b0;

      if (accept) begin
        case (state)
          HDR: begin
            if (hdr_ok) begin
              rem   <= len - 16'(UDP_HDR_BYTES);
              state <= FWD;
            end else begin
              hdr_drop_o <= 1'b1;
              drop_cnt_o <= sat_inc(drop_cnt_o);
              state      <= ip_axis_tlast_i ? HDR : DROP;
            end
          end
          FWD: begin
            udp_axis_tvalid_o <= 1'b1;
            udp_axis_tdata_o  <= ip_axis_tdata_i;
            if (fwd_done) begin
              udp_axis_tkeep_o <= ip_axis_tkeep_i & keep_from_count(rem[3:0]);
              udp_axis_tlast_o <= 1'b1;
              udp_axis_tuser_o <= ip_axis_tuser_i;
              rem              <= '0;
              state            <= ip_axis_tlast_i ? HDR : TRIM;
            end else if (ip_axis_tlast_i) begin
              // Packet ended before the UDP length was satisfied.
              udp_axis_tkeep_o <= ip_axis_tkeep_i;
              udp_axis_tlast_o <= 1'b1;
              udp_axis_tuser_o <= 1'b1;
              len_err_o        <= 1'b1;
              state            <= HDR;
            end else begin
              udp_axis_tkeep_o <= ip_axis_tkeep_i;
              udp_axis_tlast_o <= 1'b0;
              udp_axis_tuser_o <= ip_axis_tuser_i;
              rem              <= rem - {12'd0, nbytes};
            end
          end
          TRIM, DROP: begin
            if (ip_axis_tlast_i) state <= HDR;
          end
          default: state <= HDR;
        endcase
      end
    end
  end

endmodule
